// File: rtl/tl_async_crossing_sink.sv
// Sink half of the TileLink async crossing: terminates the depth-1 A queue and sources the depth-1 D queue.
// Define TL_ASYNC_SINK_CHECK_EN to compile in the protocol checker. SYNC_STAGES legal range is 2..4.
module tl_async_crossing_sink #(
    parameter int SYNC_STAGES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  auto_in_a_mem_0_opcode,
    input  logic [8:0]  auto_in_a_mem_0_address,
    input  logic [31:0] auto_in_a_mem_0_data,
    input  logic        auto_in_a_widx,
    output logic        auto_in_a_ridx,
    input  logic        auto_in_a_safe_widx_valid,
    output logic        auto_in_a_safe_ridx_valid,
    input  logic        auto_in_a_safe_source_reset_n,
    output logic        auto_in_a_safe_sink_reset_n,
    output logic [2:0]  auto_in_d_mem_0_opcode,
    output logic [1:0]  auto_in_d_mem_0_size,
    output logic        auto_in_d_mem_0_source,
    output logic [31:0] auto_in_d_mem_0_data,
    output logic        auto_in_d_widx,
    input  logic        auto_in_d_ridx,
    output logic        auto_in_d_safe_widx_valid,
    input  logic        auto_in_d_safe_ridx_valid,
    output logic        auto_in_d_safe_source_reset_n,
    input  logic        auto_in_d_safe_sink_reset_n,
    input  logic        auto_out_a_ready,
    output logic        auto_out_a_valid,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [8:0]  auto_out_a_bits_address,
    output logic [31:0] auto_out_a_bits_data,
    output logic        auto_out_d_ready,
    input  logic        auto_out_d_valid,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [1:0]  auto_out_d_bits_size,
    input  logic        auto_out_d_bits_source,
    input  logic [31:0] auto_out_d_bits_data
);

    localparam int IDX_A_WIDX    = 0;
    localparam int IDX_A_WVALID  = 1;
    localparam int IDX_A_SRC_RST = 2;
    localparam int IDX_D_RIDX    = 3;
    localparam int IDX_D_RVALID  = 4;
    localparam int IDX_D_SNK_RST = 5;

    logic [5:0]                    async_s;
    logic [SYNC_STAGES-1:0][5:0]   sync_r;
    logic                          widx_sync_s;
    logic                          live_a_s;
    logic                          ridx_d_sync_s;
    logic                          ridx_d_sync_nxt_s;
    logic                          live_d_s;
    logic                          live_d_nxt_s;

    logic                          a_valid_r;
    logic [2:0]                    a_opcode_r;
    logic [8:0]                    a_address_r;
    logic [31:0]                   a_data_r;
    logic                          ridx_a_r;
    logic                          a_ridx_valid_r;
    logic                          a_was_live_r;
    logic                          a_sink_rst_n_r;
    logic                          a_empty_s;
    logic                          a_fire_s;
    logic                          a_load_s;

    logic                          widx_d_r;
    logic                          widx_d_nxt_s;
    logic                          d_ready_r;
    logic                          d_fire_s;
    logic                          d_widx_valid_r;
    logic                          d_src_rst_n_r;
    logic [2:0]                    d_opcode_r;
    logic [1:0]                    d_size_r;
    logic                          d_source_r;
    logic [31:0]                   d_data_r;

    assign async_s = {auto_in_d_safe_sink_reset_n, auto_in_d_safe_ridx_valid, auto_in_d_ridx,
                      auto_in_a_safe_source_reset_n, auto_in_a_safe_widx_valid, auto_in_a_widx};

    // Shift every asynchronous input through its SYNC_STAGES-deep chain
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{6'd0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_s};
        end
    end

    // The *_nxt values are what the last stage holds after the coming edge, so registered ready lines up
    assign widx_sync_s       = sync_r[SYNC_STAGES-1][IDX_A_WIDX];
    assign live_a_s          = sync_r[SYNC_STAGES-1][IDX_A_WVALID] & sync_r[SYNC_STAGES-1][IDX_A_SRC_RST];
    assign ridx_d_sync_s     = sync_r[SYNC_STAGES-1][IDX_D_RIDX];
    assign ridx_d_sync_nxt_s = sync_r[SYNC_STAGES-2][IDX_D_RIDX];
    assign live_d_s          = sync_r[SYNC_STAGES-1][IDX_D_RVALID] & sync_r[SYNC_STAGES-1][IDX_D_SNK_RST];
    assign live_d_nxt_s      = sync_r[SYNC_STAGES-2][IDX_D_RVALID] & sync_r[SYNC_STAGES-2][IDX_D_SNK_RST];

    // A-side load and fire decisions
    always_comb begin
        a_empty_s = (widx_sync_s == ridx_a_r);
        a_fire_s  = a_valid_r & auto_out_a_ready;
        a_load_s  = ~a_empty_s & live_a_s & (~a_valid_r | auto_out_a_ready);
    end

    // A output register, read pointer and liveness handshake; losing the source flushes the queue
    always_ff @(posedge clock) begin
        if (reset) begin
            a_valid_r      <= 1'b0;
            a_opcode_r     <= 3'd0;
            a_address_r    <= 9'd0;
            a_data_r       <= 32'd0;
            ridx_a_r       <= 1'b0;
            a_ridx_valid_r <= 1'b0;
            a_was_live_r   <= 1'b0;
            a_sink_rst_n_r <= 1'b0;
        end else begin
            a_sink_rst_n_r <= 1'b1;
            a_ridx_valid_r <= live_a_s | ~a_was_live_r;
            a_was_live_r   <= a_was_live_r | live_a_s;
            if (!live_a_s) begin
                a_valid_r <= 1'b0;
                ridx_a_r  <= widx_sync_s;
            end else if (a_load_s) begin
                a_valid_r   <= 1'b1;
                a_opcode_r  <= auto_in_a_mem_0_opcode;
                a_address_r <= auto_in_a_mem_0_address;
                a_data_r    <= auto_in_a_mem_0_data;
                ridx_a_r    <= ~ridx_a_r;
            end else if (a_fire_s) begin
                a_valid_r <= 1'b0;
            end
        end
    end

    assign d_fire_s = auto_out_d_valid & d_ready_r;

    // Next D write pointer: realigned to the reader while the far side is down
    always_comb begin
        if (!live_d_s) begin
            widx_d_nxt_s = ridx_d_sync_s;
        end else if (d_fire_s) begin
            widx_d_nxt_s = ~widx_d_r;
        end else begin
            widx_d_nxt_s = widx_d_r;
        end
    end

    // D mailbox, write pointer and ready (mailbox free and far side live)
    always_ff @(posedge clock) begin
        if (reset) begin
            widx_d_r       <= 1'b0;
            d_ready_r      <= 1'b0;
            d_widx_valid_r <= 1'b0;
            d_src_rst_n_r  <= 1'b0;
            d_opcode_r     <= 3'd0;
            d_size_r       <= 2'd0;
            d_source_r     <= 1'b0;
            d_data_r       <= 32'd0;
        end else begin
            widx_d_r       <= widx_d_nxt_s;
            d_ready_r      <= (widx_d_nxt_s == ridx_d_sync_nxt_s) & live_d_nxt_s;
            d_widx_valid_r <= 1'b1;
            d_src_rst_n_r  <= 1'b1;
            if (d_fire_s) begin
                d_opcode_r <= auto_out_d_bits_opcode;
                d_size_r   <= auto_out_d_bits_size;
                d_source_r <= auto_out_d_bits_source;
                d_data_r   <= auto_out_d_bits_data;
            end
        end
    end

    assign auto_in_a_ridx                = ridx_a_r;
    assign auto_in_a_safe_ridx_valid     = a_ridx_valid_r;
    assign auto_in_a_safe_sink_reset_n   = a_sink_rst_n_r;
    assign auto_out_a_valid              = a_valid_r;
    assign auto_out_a_bits_opcode        = a_opcode_r;
    assign auto_out_a_bits_address       = a_address_r;
    assign auto_out_a_bits_data          = a_data_r;
    assign auto_in_d_mem_0_opcode        = d_opcode_r;
    assign auto_in_d_mem_0_size          = d_size_r;
    assign auto_in_d_mem_0_source        = d_source_r;
    assign auto_in_d_mem_0_data          = d_data_r;
    assign auto_in_d_widx                = widx_d_r;
    assign auto_in_d_safe_widx_valid     = d_widx_valid_r;
    assign auto_in_d_safe_source_reset_n = d_src_rst_n_r;
    assign auto_out_d_ready              = d_ready_r;

`ifdef TL_ASYNC_SINK_CHECK_EN
    tl_async_crossing_sink_checker u_checker (
        .clock     (clock),
        .reset     (reset),
        .widx_sync (widx_sync_s),
        .ridx_a    (ridx_a_r),
        .live_a    (live_a_s),
        .a_valid   (a_valid_r),
        .a_ready   (auto_out_a_ready),
        .a_bits    ({a_opcode_r, a_address_r, a_data_r}),
        .d_valid   (auto_out_d_valid),
        .d_ready   (d_ready_r)
    );
`else
    // Protocol checker not compiled in; datapath is unchanged.
`endif

endmodule

`ifdef TL_ASYNC_SINK_CHECK_EN
// Protocol checker for the sink crossing: compares each cycle against the previous one.
module tl_async_crossing_sink_checker (
    input logic        clock,
    input logic        reset,
    input logic        widx_sync,
    input logic        ridx_a,
    input logic        live_a,
    input logic        a_valid,
    input logic        a_ready,
    input logic [43:0] a_bits,
    input logic        d_valid,
    input logic        d_ready
);

    logic        armed_r;
    logic        widx_q_r;
    logic        ridx_q_r;
    logic        live_q_r;
    logic        a_valid_q_r;
    logic        a_ready_q_r;
    logic [43:0] a_bits_q_r;
    logic        d_valid_q_r;
    logic        d_ready_q_r;

    // Previous-cycle history
    always_ff @(posedge clock) begin
        if (reset) begin
            armed_r     <= 1'b0;
            widx_q_r    <= 1'b0;
            ridx_q_r    <= 1'b0;
            live_q_r    <= 1'b0;
            a_valid_q_r <= 1'b0;
            a_ready_q_r <= 1'b0;
            a_bits_q_r  <= 44'd0;
            d_valid_q_r <= 1'b0;
            d_ready_q_r <= 1'b0;
        end else begin
            armed_r     <= 1'b1;
            widx_q_r    <= widx_sync;
            ridx_q_r    <= ridx_a;
            live_q_r    <= live_a;
            a_valid_q_r <= a_valid;
            a_ready_q_r <= a_ready;
            a_bits_q_r  <= a_bits;
            d_valid_q_r <= d_valid;
            d_ready_q_r <= d_ready;
        end
    end

    // Rule evaluation while out of reset
    always_ff @(posedge clock) begin
        if (!reset && armed_r) begin
            if (live_a && live_q_r && (widx_sync != widx_q_r) && (widx_q_r != ridx_q_r)) begin
                $error("tl_async_crossing_sink: widx toggled again before ridx answered");
                $fatal(1, "tl_async_crossing_sink: protocol check");
            end
            if (a_valid_q_r && !a_ready_q_r && a_valid && (a_bits != a_bits_q_r)) begin
                $error("tl_async_crossing_sink: A bits changed while stalled");
                $fatal(1, "tl_async_crossing_sink: protocol check");
            end
            if (d_valid_q_r && !d_ready_q_r && !d_valid) begin
                $error("tl_async_crossing_sink: D valid dropped before fire");
                $fatal(1, "tl_async_crossing_sink: protocol check");
            end
        end
    end

endmodule
`endif
